uart8_tx_arbiter: RTL and testbench
===================================

Name: uart8_tx_arbiter

Overview:
- Round-robin arbiter that shares one Uart8 transmitter between NUM_REQ byte sources. Sits in the `clk` domain, between client logic and the Uart8 tx interface (`txEn`, `txStart`, `in`, `txBusy`).
- Latches the winning byte, holds `txStart` until the transmitter reports busy, then waits for the frame to finish.
- Acks the requester on completion, or flags an error if the transmitter never starts.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- START_TIMEOUT, 65535, clk cycles to wait in START for synchronized busy before aborting; must be at least 2 tx baud periods in clk cycles.
- TO_W, 16, timeout counter width; must hold START_TIMEOUT.

Ports:
- clk  in  1  board clock (same clock fed to Uart8)
- rstN  in  1  asynchronous active-low reset
- en  in  1  arbiter enable; 0 blocks new grants, an in-flight transfer completes
- reqValid  in  NUM_REQ  per-requester request, held high until reqAck/reqErr
- reqData  in  8*NUM_REQ  byte i at [8*i+7:8*i]; sampled only at grant
- reqAck  out  NUM_REQ  one-cycle pulse: byte i transmitted
- reqErr  out  NUM_REQ  one-cycle pulse: byte i aborted on start timeout
- grantId  out  $clog2(NUM_REQ)  index of current/last granted requester
- busy  out  1  high in any state other than IDLE
- txEn  out  1  to Uart8 txEn; registered copy of en
- txStart  out  1  to Uart8 txStart
- txData  out  8  to Uart8 in; stable for the whole transfer
- txBusy  in  1  from Uart8 txBusy; asynchronous to clk (generated tx clock)

Behaviour:
- Reset (rstN=0, async): state=IDLE; reqAck=0, reqErr=0, txStart=0, txData=0, txEn=0, grantId=0, busy=0; lastGrant=NUM_REQ-1, so requester 0 has first priority; timeout counter=0; synchronizer flops=0.
- Reset mid-transfer: everything returns to the reset values immediately; txStart drops asynchronously. No ack/err is issued for the interrupted byte.
- txBusy passes through a 2-flop synchronizer giving busyS; 2-cycle latency. All decisions use busyS.
- State IDLE:
  - Grants when en=1, busyS=0 and any reqValid=1.
  - Winner is the first set bit searching lastGrant+1, lastGrant+2, ... modulo NUM_REQ.
  - Next cycle: state=START, txStart=1, txData=reqData[winner], grantId=winner, counter cleared.
  - Grant-to-txStart latency: 1 cycle.
- State START:
  - txStart held 1; counter increments each cycle.
  - busyS=1: txStart=0, go to SEND.
  - Counter reaches START_TIMEOUT with busyS=0: txStart=0, reqErr[grantId] pulses 1 cycle, lastGrant=grantId, go to IDLE.
  - If both occur in the same cycle, busyS wins (go to SEND, no error).
- State SEND: txStart=0; wait for busyS=0, then go to DONE.
- State DONE (1 cycle): reqAck[grantId]=1, lastGrant=grantId, go to IDLE.
  - A new grant can occur in the IDLE cycle that follows, giving a 2-cycle minimum gap between ack and the next txStart.
- Only one reqAck/reqErr bit is high per cycle; the two are never high together.
- reqValid deassert after grant: ignored; the transfer completes and reqAck still pulses. The requester must not reuse that pulse as a new request.
- en=0: no new grant; START/SEND/DONE proceed normally. txEn follows en with 1-cycle latency.
- Wrap-around: lastGrant=NUM_REQ-1 searches from 0. A single persistent requester is re-granted back-to-back.
- busyS=1 in IDLE (stale busy): no grant until it clears.

Test Plan:
- Single request: NUM_REQ=4, reqValid=0001, reqData[7:0]=8'hA5; Uart8 at 100MHz/9600 → txStart rises 1 cycle after grant, drops 2–3 cycles after txBusy rises; tx line shows 0,A5 LSB-first,1; reqAck=0001 pulses once after txBusy falls; busy=0 afterwards.
- Round robin: reqValid=1111 held with bytes 11,22,33,44 → service order 0,1,2,3,0. grantId sequence 0,1,2,3,0, one ack each, no starvation.
- Wrap/priority: after grant to 3, reqValid=1001 → requester 0 granted next, then 3.
- Timeout: START_TIMEOUT=20, txBusy tied 0, reqValid=0100 → txStart high exactly 20 cycles, reqErr=0100 one-cycle pulse, reqAck never asserts, state returns to IDLE.
- Enable gating: en=0 with reqValid=0010 → no txStart for 100 cycles. Drive en=0 mid-SEND → current byte still acks, no further grant.
- Async reset during SEND: rstN=0 → txStart=0, busy=0, reqAck=0 with no clock edge. After release, reqValid=0001 is granted to requester 0 first.

Source files
------------

// File: rtl/uart8_tx_arbiter_if.sv
`default_nettype none
//==============================================================================
// Module   : uart8_tx_arbiter_if
// Brief    : Requester and Uart8-tx bundle for the round-robin tx arbiter
// Revision : 1.0
//==============================================================================
interface uart8_tx_arbiter_if #(
   parameter int NUM_REQ = 4
);
   localparam int c_ID_W = $clog2(NUM_REQ);

   logic                  en;
   logic [NUM_REQ-1:0]    reqValid;
   logic [8*NUM_REQ-1:0]  reqData;
   logic [NUM_REQ-1:0]    reqAck;
   logic [NUM_REQ-1:0]    reqErr;
   logic [c_ID_W-1:0]     grantId;
   logic                  busy;
   logic                  txEn;
   logic                  txStart;
   logic [7:0]            txData;
   logic                  txBusy;

   // Arbiter side.
   modport slave (
      input  en, reqValid, reqData, txBusy,
      output reqAck, reqErr, grantId, busy, txEn, txStart, txData
   );

   // Environment side: clients plus the Uart8 transmitter.
   modport master (
      output en, reqValid, reqData, txBusy,
      input  reqAck, reqErr, grantId, busy, txEn, txStart, txData
   );
endinterface
`default_nettype wire

// File: rtl/uart8_tx_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : uart8_tx_arbiter
// Brief    : Round-robin arbiter sharing one Uart8 transmitter among NUM_REQ
//            byte sources, with start timeout and per-requester ack/err pulses
// Revision : 1.0
//==============================================================================
module uart8_tx_arbiter #(
   parameter int NUM_REQ       = 4,
   parameter int START_TIMEOUT = 65535,
   parameter int TO_W          = 16
) (
   input  logic               clk,
   input  logic               rstN,
   uart8_tx_arbiter_if.slave  bus
);
   localparam int                c_ID_W    = $clog2(NUM_REQ);
   localparam logic [c_ID_W:0]   c_NUM_REQ = (c_ID_W+1)'(NUM_REQ);
   localparam logic [c_ID_W-1:0] c_LAST_ID = c_ID_W'(NUM_REQ - 1);
   localparam logic [TO_W-1:0]   c_TIMEOUT = TO_W'(START_TIMEOUT);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_START = 2'd1;
   localparam logic [1:0] c_SEND  = 2'd2;
   localparam logic [1:0] c_DONE  = 2'd3;

   logic [1:0]         r_state;
   logic [c_ID_W-1:0]  r_lastGrant;
   logic [c_ID_W-1:0]  r_grantId;
   logic [TO_W-1:0]    r_count;
   logic               r_txStart;
   logic [7:0]         r_txData;
   logic               r_txEn;
   logic [NUM_REQ-1:0] r_reqAck;
   logic [NUM_REQ-1:0] r_reqErr;
   logic               r_busyMeta;
   logic               r_busyS;

   logic [7:0]         w_reqByte [NUM_REQ];
   logic [c_ID_W:0]    w_cand;
   logic [c_ID_W-1:0]  w_winner;
   logic               w_found;
   logic               w_grant;
   logic [TO_W-1:0]    w_countNext;
   logic [NUM_REQ-1:0] w_grantOneHot;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_reqByte
      assign w_reqByte[i] = bus.reqData[8*i +: 8];
   end

   // Rotating priority: the first requester after the last one served wins.
   always_comb begin
      w_cand   = '0;
      w_winner = '0;
      w_found  = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_cand = {1'b0, r_lastGrant} + (c_ID_W+1)'(k);
         if (w_cand >= c_NUM_REQ) begin
            w_cand = w_cand - c_NUM_REQ;
         end
         if (!w_found && bus.reqValid[w_cand[c_ID_W-1:0]]) begin
            w_found  = 1'b1;
            w_winner = w_cand[c_ID_W-1:0];
         end
      end
   end

   assign w_grant       = bus.en && !r_busyS && w_found;
   assign w_countNext   = r_count + TO_W'(1);
   assign w_grantOneHot = NUM_REQ'(1) << r_grantId;

   // txBusy comes from the generated tx clock domain.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_busyMeta <= 1'b0;
         r_busyS    <= 1'b0;
         r_txEn     <= 1'b0;
      end else begin
         r_busyMeta <= bus.txBusy;
         r_busyS    <= r_busyMeta;
         r_txEn     <= bus.en;
      end
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_state     <= c_IDLE;
         r_lastGrant <= c_LAST_ID;
         r_grantId   <= '0;
         r_count     <= '0;
         r_txStart   <= 1'b0;
         r_txData    <= '0;
         r_reqAck    <= '0;
         r_reqErr    <= '0;
      end else begin
         r_reqAck <= '0;
         r_reqErr <= '0;
         case (r_state)
            c_IDLE: begin
               if (w_grant) begin
                  r_state   <= c_START;
                  r_txStart <= 1'b1;
                  r_txData  <= w_reqByte[w_winner];
                  r_grantId <= w_winner;
                  r_count   <= '0;
               end
            end
            c_START: begin
               r_count <= w_countNext;
               // A busy seen on the final timeout cycle still counts as a start.
               if (r_busyS) begin
                  r_txStart <= 1'b0;
                  r_state   <= c_SEND;
               end else if (w_countNext == c_TIMEOUT) begin
                  r_txStart   <= 1'b0;
                  r_reqErr    <= w_grantOneHot;
                  r_lastGrant <= r_grantId;
                  r_state     <= c_IDLE;
               end
            end
            c_SEND: begin
               if (!r_busyS) begin
                  r_reqAck    <= w_grantOneHot;
                  r_lastGrant <= r_grantId;
                  r_state     <= c_DONE;
               end
            end
            c_DONE: begin
               r_state <= c_IDLE;
            end
            default: begin
               r_state <= c_IDLE;
            end
         endcase
      end
   end

   assign bus.reqAck  = r_reqAck;
   assign bus.reqErr  = r_reqErr;
   assign bus.grantId = r_grantId;
   assign bus.busy    = (r_state != c_IDLE);
   assign bus.txEn    = r_txEn;
   assign bus.txStart = r_txStart;
   assign bus.txData  = r_txData;

   a_singleResponse : assert property (@(posedge clk) disable iff (!rstN)
      $onehot0(r_reqAck | r_reqErr) && ((r_reqAck & r_reqErr) == '0));

   a_startOnlyInStart : assert property (@(posedge clk) disable iff (!rstN)
      r_txStart == (r_state == c_START));
endmodule
`default_nettype wire

// File: tb/tb_uart8_tx_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : tb_uart8_tx_arbiter
// Brief    : Self-checking bench for uart8_tx_arbiter with a Uart8 busy model
// Revision : 1.0
//==============================================================================
module tb_uart8_tx_arbiter;
   localparam int NREQ    = 4;
   localparam int TIMEOUT = 20;

   logic clk  = 1'b0;
   logic rstN = 1'b1;

   uart8_tx_arbiter_if #(.NUM_REQ(NREQ)) bus ();

   uart8_tx_arbiter #(
      .NUM_REQ       (NREQ),
      .START_TIMEOUT (TIMEOUT),
      .TO_W          (16)
   ) dut (
      .clk  (clk),
      .rstN (rstN),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: one in-flight transfer record plus expected outputs.
   bit         mActive, mLaunched, mTail;
   int         mStartLeft, mLast;
   logic       mS1, mS2;
   logic       eTxStart, eTxEn;
   logic [1:0] eGrant;
   logic [7:0] eData;
   logic [3:0] eAck, eErr;

   // Uart8 busy generator and observation logs.
   int   uRemain, uDelay, uMaxDelay, uIgnorePct;
   bit   uArmed, uNoise, randMode;
   logic prevStart;
   int   gLog[$];
   logic [7:0] dLog[$];
   int   ackCnt[NREQ], errCnt[NREQ];
   int   hiCnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
      end
   endtask

   function automatic int pickNext(input int last, input logic [NREQ-1:0] v);
      logic [2*NREQ-1:0] dbl;
      dbl = {v, v} >> (last + 1);
      for (int j = 0; j < NREQ; j++) begin
         if (dbl[j]) return (last + 1 + j) % NREQ;
      end
      return 0;
   endfunction

   task automatic modelReset();
      mActive = 1'b0; mLaunched = 1'b0; mTail = 1'b0;
      mStartLeft = 0; mLast = NREQ - 1;
      mS1 = 1'b0; mS2 = 1'b0;
      eTxStart = 1'b0; eTxEn = 1'b0; eGrant = '0; eData = '0; eAck = '0; eErr = '0;
   endtask

   // Predicts outputs after the coming edge from the inputs now applied.
   task automatic modelAdvance();
      logic bs;
      int   w;
      bs   = mS2;
      eAck = '0;
      eErr = '0;
      if (mTail) begin
         mTail   = 1'b0;
         mActive = 1'b0;
      end else if (mActive && !mLaunched) begin
         if (bs) begin
            mLaunched = 1'b1;
            eTxStart  = 1'b0;
         end else begin
            mStartLeft--;
            if (mStartLeft == 0) begin
               eTxStart     = 1'b0;
               eErr[eGrant] = 1'b1;
               mLast        = int'(eGrant);
               mActive      = 1'b0;
            end
         end
      end else if (mActive) begin
         if (!bs) begin
            eAck[eGrant] = 1'b1;
            mLast        = int'(eGrant);
            mTail        = 1'b1;
         end
      end else if (bus.en && !bs && bus.reqValid != '0) begin
         w          = pickNext(mLast, bus.reqValid);
         eGrant     = 2'(w);
         eData      = bus.reqData[8*w +: 8];
         eTxStart   = 1'b1;
         mActive    = 1'b1;
         mLaunched  = 1'b0;
         mStartLeft = TIMEOUT;
      end
      eTxEn = bus.en;
      mS2   = mS1;
      mS1   = bus.txBusy;
   endtask

   task automatic uartStep();
      if (uRemain > 0) begin
         uRemain--;
         if (uRemain == 0) bus.txBusy = 1'b0;
      end else if (uDelay > 0) begin
         uDelay--;
         if (uDelay == 0) begin
            bus.txBusy = 1'b1;
            uRemain    = int'($urandom_range(3, 25));
         end
      end else if (bus.txStart && !uArmed) begin
         uArmed = 1'b1;
         if (int'($urandom_range(0, 99)) >= uIgnorePct) uDelay = int'($urandom_range(1, uMaxDelay));
      end else if (uNoise && !bus.txStart && $urandom_range(0, 99) < 2) begin
         bus.txBusy = 1'b1;
         uRemain    = int'($urandom_range(1, 5));
      end
      if (!bus.txStart) uArmed = 1'b0;
   endtask

   task automatic requesterStep();
      for (int i = 0; i < NREQ; i++) begin
         if (bus.reqAck[i] || bus.reqErr[i]) bus.reqValid[i] = 1'b0;
         else if (!bus.reqValid[i] && $urandom_range(0, 99) < 25) bus.reqValid[i] = 1'b1;
      end
      bus.reqData = $urandom();
      bus.en      = ($urandom_range(0, 15) != 0);
   endtask

   task automatic step();
      modelAdvance();
      @(posedge clk);
      #1;
      chk("txStart", {31'd0, bus.txStart}, {31'd0, eTxStart});
      chk("txData",  {24'd0, bus.txData},  {24'd0, eData});
      chk("grantId", {30'd0, bus.grantId}, {30'd0, eGrant});
      chk("busy",    {31'd0, bus.busy},    {31'd0, mActive});
      chk("reqAck",  {28'd0, bus.reqAck},  {28'd0, eAck});
      chk("reqErr",  {28'd0, bus.reqErr},  {28'd0, eErr});
      chk("txEn",    {31'd0, bus.txEn},    {31'd0, eTxEn});
      if (bus.txStart && !prevStart) begin
         gLog.push_back(int'(bus.grantId));
         dLog.push_back(bus.txData);
      end
      prevStart = bus.txStart;
      if (bus.txStart) hiCnt++;
      for (int i = 0; i < NREQ; i++) begin
         ackCnt[i] += int'(bus.reqAck[i]);
         errCnt[i] += int'(bus.reqErr[i]);
      end
      uartStep();
      if (randMode) requesterStep();
   endtask

   task automatic clearLogs();
      gLog.delete();
      dLog.delete();
      for (int i = 0; i < NREQ; i++) begin
         ackCnt[i] = 0;
         errCnt[i] = 0;
      end
      hiCnt = 0;
   endtask

   // Asserts reset away from any clock edge and checks the outputs before one arrives.
   task automatic resetDut();
      rstN = 1'b0;
      #1;
      chk("rst_txStart", {31'd0, bus.txStart}, 0);
      chk("rst_busy",    {31'd0, bus.busy},    0);
      chk("rst_reqAck",  {28'd0, bus.reqAck},  0);
      chk("rst_reqErr",  {28'd0, bus.reqErr},  0);
      chk("rst_grantId", {30'd0, bus.grantId}, 0);
      chk("rst_txData",  {24'd0, bus.txData},  0);
      chk("rst_txEn",    {31'd0, bus.txEn},    0);
      modelReset();
      bus.txBusy = 1'b0;
      uRemain = 0; uDelay = 0; uArmed = 1'b0;
      prevStart = 1'b0;
      @(negedge clk);
      rstN = 1'b1;
   endtask

   task automatic waitRises(input int n, input int bound, input string name);
      int c;
      c = 0;
      while (gLog.size() < n && c < bound) begin
         step();
         c++;
      end
      chk(name, gLog.size(), n);
   endtask

   task automatic waitSend(input int bound, input string name);
      int c;
      bit seen;
      c = 0;
      seen = 1'b0;
      while (!seen && c < bound) begin
         step();
         c++;
         seen = bus.txBusy && !bus.txStart && bus.busy;
      end
      chk(name, {31'd0, seen}, 1);
   endtask

   task automatic waitAck(input int id, input int bound, input string name);
      int c;
      bit seen;
      c = 0;
      seen = 1'b0;
      while (!seen && c < bound) begin
         step();
         c++;
         seen = bus.reqAck[id];
      end
      chk(name, {31'd0, seen}, 1);
   endtask

   int         rrExp[5]  = '{0, 1, 2, 3, 0};
   logic [7:0] rrData[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

   initial begin
      logic [3:0] errSeen;
      int         c;
      bus.en = 1'b0; bus.reqValid = '0; bus.reqData = '0; bus.txBusy = 1'b0;
      uMaxDelay = 4; uIgnorePct = 0; uNoise = 1'b0; randMode = 1'b0;
      clearLogs();
      #1;
      resetDut();

      // Single request.
      bus.en = 1'b1; bus.reqValid = 4'b0001; bus.reqData = 32'h0000_00A5;
      waitRises(1, 20, "p1_rise");
      chk("p1_grant", gLog[0], 0);
      chk("p1_data", {24'd0, dLog[0]}, 32'hA5);
      waitAck(0, 200, "p1_ack");
      bus.reqValid = '0;
      repeat (5) step();
      chk("p1_idle", {31'd0, bus.busy}, 0);
      chk("p1_ackCount", ackCnt[0], 1);

      // Round robin with all requesters held.
      #2; resetDut(); clearLogs();
      bus.reqData = 32'h4433_2211; bus.reqValid = 4'b1111;
      waitRises(5, 600, "p2_rises");
      bus.reqValid = '0;
      repeat (80) step();
      for (int k = 0; k < 5; k++) begin
         chk("p2_order", gLog[k], rrExp[k]);
         chk("p2_data", {24'd0, dLog[k]}, {24'd0, rrData[k]});
      end
      chk("p2_ack0", ackCnt[0], 2);
      chk("p2_ack1", ackCnt[1], 1);
      chk("p2_ack3", ackCnt[3], 1);

      // Wrap-around priority after serving requester 3.
      #2; resetDut(); clearLogs();
      bus.reqValid = 4'b1000;
      waitRises(1, 50, "p3_first");
      chk("p3_grant3", gLog[0], 3);
      bus.reqValid = 4'b1001;
      waitRises(3, 600, "p3_rises");
      bus.reqValid = '0;
      chk("p3_wrap0", gLog[1], 0);
      chk("p3_then3", gLog[2], 3);
      repeat (80) step();

      // Start timeout with a transmitter that never goes busy.
      #2; resetDut(); clearLogs();
      uIgnorePct = 100;
      bus.reqValid = 4'b0100;
      errSeen = '0;
      c = 0;
      while (errSeen == '0 && c < 100) begin
         step();
         c++;
         if (bus.reqErr != '0) errSeen = bus.reqErr;
      end
      bus.reqValid = '0;
      chk("p4_errVec", {28'd0, errSeen}, 32'h4);
      chk("p4_startCycles", hiCnt, TIMEOUT);
      repeat (30) step();
      chk("p4_errCount", errCnt[2], 1);
      chk("p4_noAck", ackCnt[0] + ackCnt[1] + ackCnt[2] + ackCnt[3], 0);
      chk("p4_idle", {31'd0, bus.busy}, 0);
      uIgnorePct = 0;

      // Enable gating, including en dropped mid-transfer.
      #2; resetDut(); clearLogs();
      bus.en = 1'b0; bus.reqValid = 4'b0010;
      repeat (100) step();
      chk("p5_blocked", gLog.size(), 0);
      bus.en = 1'b1;
      waitSend(100, "p5_send");
      bus.en = 1'b0;
      repeat (100) step();
      chk("p5_ack", ackCnt[1], 1);
      chk("p5_oneGrant", gLog.size(), 1);

      // Asynchronous reset during SEND, then priority restarts at 0.
      bus.en = 1'b1; bus.reqValid = 4'b0001;
      waitSend(150, "p6_send");
      #2; resetDut(); clearLogs();
      bus.en = 1'b1; bus.reqValid = 4'b0011;
      waitRises(1, 50, "p6_rise");
      chk("p6_grant0", gLog[0], 0);
      bus.reqValid = '0;
      repeat (80) step();

      // Randomised traffic with stale busy, late starts and ignored starts.
      clearLogs();
      uNoise = 1'b1; uIgnorePct = 10; uMaxDelay = 22; randMode = 1'b1;
      repeat (4000) step();
      randMode = 1'b0; uNoise = 1'b0;
      bus.reqValid = '0; bus.en = 1'b1;
      repeat (100) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
